spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 23 ++
 rtl/spi_arbiter_if.sv | 30 +++
 rtl/spi_arb_client_latch.sv | 26 ++
 rtl/spi_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-client SPI arbiter.
package spi_arb_pkg;
  localparam int          NUM_CLIENTS     = 2;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0] mosi;
    logic [5:0]  nbits;
  } spi_cmd_t;

  // Round-robin pick: on a tie the client not served last wins.
  function automatic logic rr_pick(input logic [NUM_CLIENTS-1:0] pend, input logic last);
    if (pend[0] && pend[1]) return ~last;
    return pend[1];
  endfunction
endpackage

// File: rtl/spi_arbiter_if.sv
// Client-side and SPI-master-side signal bundle of the arbiter.
interface spi_arbiter_if;
  logic        c0_request,   c1_request;
  logic [31:0] c0_mosi_data, c1_mosi_data;
  logic [5:0]  c0_nbits,     c1_nbits;
  logic        c0_ready,     c1_ready;
  logic [31:0] c0_miso_data, c1_miso_data;
  logic [31:0] spi_mosi_data;
  logic [5:0]  spi_nbits;
  logic        spi_request;
  logic        spi_ready;
  logic [31:0] spi_miso_data;
  logic        grant_id;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  c0_request, c1_request, c0_mosi_data, c1_mosi_data, c0_nbits, c1_nbits,
    input  spi_ready, spi_miso_data,
    output c0_ready, c1_ready, c0_miso_data, c1_miso_data,
    output spi_mosi_data, spi_nbits, spi_request, grant_id, busy, timeout_err
  );

  modport master (
    output c0_request, c1_request, c0_mosi_data, c1_mosi_data, c0_nbits, c1_nbits,
    output spi_ready, spi_miso_data,
    input  c0_ready, c1_ready, c0_miso_data, c1_miso_data,
    input  spi_mosi_data, spi_nbits, spi_request, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/spi_arb_client_latch.sv
// Per-client pending flag and command capture; repeat pulses while pending are dropped.
module spi_arb_client_latch
  import spi_arb_pkg::*;
(
  input  logic     clk_in,
  input  logic     nrst,
  input  logic     request,
  input  spi_cmd_t cmd,
  input  logic     clear,
  output logic     pending,
  output spi_cmd_t cmd_q
);

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      pending <= 1'b0;
      cmd_q   <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (request && !pending) begin
      pending <= 1'b1;
      cmd_q   <= cmd;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between two clients, with a per-transfer timeout.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          clk_in,
  input  logic          nrst,
  spi_arbiter_if.slave  bus
);

  logic [NUM_CLIENTS-1:0]       req, pend, clr;
  logic [NUM_CLIENTS-1:0][31:0] mosi_in;
  logic [NUM_CLIENTS-1:0][5:0]  nbits_in;
  spi_cmd_t                     cmd_q [NUM_CLIENTS];

  assign req      = {bus.c1_request,   bus.c0_request};
  assign mosi_in  = {bus.c1_mosi_data, bus.c0_mosi_data};
  assign nbits_in = {bus.c1_nbits,     bus.c0_nbits};

  arb_state_t                   state;
  logic                         grant, last_served, win, grant_now;
  logic [15:0]                  cnt;
  logic                         spi_req;
  logic [31:0]                  spi_mosi;
  logic [5:0]                   spi_nb;
  logic [NUM_CLIENTS-1:0]       ready;
  logic [NUM_CLIENTS-1:0][31:0] miso;
  logic                         busy, tmo_err;

  assign win       = rr_pick(pend, last_served);
  assign grant_now = (state == ST_IDLE) && (|pend);

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
    assign clr[g] = grant_now && (win == g[0]);

    spi_arb_client_latch u_latch (
      .clk_in  (clk_in),
      .nrst    (nrst),
      .request (req[g]),
      .cmd     ('{mosi: mosi_in[g], nbits: nbits_in[g]}),
      .clear   (clr[g]),
      .pending (pend[g]),
      .cmd_q   (cmd_q[g])
    );
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
      cnt         <= '0;
      spi_req     <= 1'b0;
      spi_mosi    <= '0;
      spi_nb      <= '0;
      ready       <= '0;
      miso        <= '0;
      busy        <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            grant       <= win;
            last_served <= win;
            spi_req     <= 1'b1;
            spi_mosi    <= cmd_q[win].mosi;
            spi_nb      <= cmd_q[win].nbits;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          spi_req <= 1'b0;
          cnt     <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.spi_ready) begin
            miso[grant]  <= bus.spi_miso_data;
            ready[grant] <= 1'b1;
            state        <= ST_DONE;
          end else if (cnt == 16'(TIMEOUT_CYCLES - 16'd1)) begin
            // Timed-out transfers report all-ones so the client can't mistake stale data.
            miso[grant]  <= 32'hFFFF_FFFF;
            ready[grant] <= 1'b1;
            tmo_err      <= 1'b1;
            state        <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          ready <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.spi_request   = spi_req;
  assign bus.spi_mosi_data = spi_mosi;
  assign bus.spi_nbits     = spi_nb;
  assign bus.c0_ready      = ready[0];
  assign bus.c1_ready      = ready[1];
  assign bus.c0_miso_data  = miso[0];
  assign bus.c1_miso_data  = miso[1];
  assign bus.grant_id      = grant;
  assign bus.busy          = busy;
  assign bus.timeout_err   = tmo_err;

endmodule
